// File: rtl/ram_arbiter.sv
// Two-master arbiter and sequencer for a single-port synchronous RAM.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise master 0 has fixed priority.
module ram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          ram_cen,
    output logic          ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic          grant_nxt;
    logic          winner_q;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic          last_grant;

    // On a tie the master that was not served last wins.
    always_comb begin
        grant_nxt = 1'b0;
        if (m0_req && m1_req)
            grant_nxt = ~last_grant;
        else if (m1_req)
            grant_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last_grant <= 1'b1;
        else if (state == RESP)
            last_grant <= winner_q;
    end
`else
    always_comb begin
        grant_nxt = 1'b0;
        if (m1_req && !m0_req)
            grant_nxt = 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (m0_req || m1_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = wr_q ? RESP : RDWAIT;
            RDWAIT:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command is captured once in IDLE so later changes on the master side are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            winner_q <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (state == IDLE && (m0_req || m1_req)) begin
                winner_q <= grant_nxt;
                wr_q     <= grant_nxt ? m1_wr    : m0_wr;
                addr_q   <= grant_nxt ? m1_addr  : m0_addr;
                wdata_q  <= grant_nxt ? m1_wdata : m0_wdata;
            end
            if (state == RDWAIT)
                rdata_q <= ram_dout;
        end
    end

    always_comb begin
        ram_cen  = 1'b0;
        ram_wen  = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        busy     = (state != IDLE);
        rdata    = rdata_q;
        case (state)
            ACCESS: begin
                ram_cen  = 1'b1;
                ram_wen  = wr_q;
                ram_addr = addr_q;
                ram_din  = wdata_q;
            end
            RESP: begin
                m0_ack = ~winner_q;
                m1_ack = winner_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 256x64 RAM; expectations follow
// RAM_ARB_ROUND_ROBIN_EN when defined, fixed priority otherwise.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_req = 1'b0, m0_wr = 1'b0;
    logic [7:0]  m0_addr = '0;
    logic [63:0] m0_wdata = '0;
    logic        m0_ack;
    logic        m1_req = 1'b0, m1_wr = 1'b0;
    logic [7:0]  m1_addr = '0;
    logic [63:0] m1_wdata = '0;
    logic        m1_ack;
    logic [63:0] rdata;
    logic        busy;
    logic        ram_cen, ram_wen;
    logic [7:0]  ram_addr;
    logic [63:0] ram_din;
    logic [63:0] ram_dout = '0;

    logic [63:0] mem [256];

    int checks = 0;
    int errors = 0;
    logic [63:0] tb_rdata = '0;
    int tb_last = 1;

    ram_arbiter #(.AW(8), .DW(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
        .rdata(rdata), .busy(busy),
        .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_cen) begin
            if (ram_wen) mem[ram_addr] <= ram_din;
            else         ram_dout <= mem[ram_addr];
        end
    end

    typedef struct {
        int          m;
        bit          wr;
        logic [7:0]  addr;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " ram_cen"},  64'(ram_cen),  64'd0);
        chk({tag, " ram_wen"},  64'(ram_wen),  64'd0);
        chk({tag, " ram_addr"}, 64'(ram_addr), 64'd0);
        chk({tag, " ram_din"},  ram_din,       64'd0);
        chk({tag, " m0_ack"},   64'(m0_ack),   64'd0);
        chk({tag, " m1_ack"},   64'(m1_ack),   64'd0);
        chk({tag, " rdata"},    rdata,         64'd0);
        chk({tag, " busy"},     64'(busy),     64'd0);
    endtask

    task automatic drive(input int m, input bit req, input bit wr, input logic [7:0] a, input logic [63:0] d);
        if (m == 0) begin
            m0_req = req; m0_wr = wr; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = req; m1_wr = wr; m1_addr = a; m1_wdata = d;
        end
    endtask

    // Single transaction from one master; checks latency, RAM pin pulse and rdata at ack.
    task automatic txn(input int m, input bit wr, input logic [7:0] a, input logic [63:0] d,
                       input logic [63:0] exp_rd);
        int lat = 0;
        int cen_cnt = 0;
        bit pin_bad = 1'b0;
        bit other = 1'b0;
        bit got = 1'b0;
        logic mine;
        logic [63:0] rd_at_ack = '0;
        logic [63:0] exp_now;
        @(negedge clk);
        drive(m, 1'b1, wr, a, d);
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (ram_cen) begin
                cen_cnt++;
                if (ram_wen !== wr || ram_addr !== a || (wr && ram_din !== d)) pin_bad = 1'b1;
            end else if (ram_wen !== 1'b0) begin
                pin_bad = 1'b1;
            end
            mine = (m == 0) ? m0_ack : m1_ack;
            if (((m == 0) ? m1_ack : m0_ack) !== 1'b0) other = 1'b1;
            if (mine === 1'b1) begin
                got = 1'b1;
                lat = i;
                rd_at_ack = rdata;
                drive(m, 1'b0, 1'b0, 8'h00, 64'd0);
            end
        end
        if (!got) drive(m, 1'b0, 1'b0, 8'h00, 64'd0);
        exp_now = wr ? tb_rdata : exp_rd;
        chk($sformatf("m%0d %s %h latency", m, wr ? "wr" : "rd", a), 64'(lat), wr ? 64'd2 : 64'd3);
        chk($sformatf("m%0d %s %h cen cycles", m, wr ? "wr" : "rd", a), 64'(cen_cnt), 64'd1);
        chk($sformatf("m%0d %s %h pins", m, wr ? "wr" : "rd", a), 64'(pin_bad), 64'd0);
        chk($sformatf("m%0d %s %h other ack", m, wr ? "wr" : "rd", a), 64'(other), 64'd0);
        chk($sformatf("m%0d %s %h rdata", m, wr ? "wr" : "rd", a), rd_at_ack, exp_now);
        tb_rdata = exp_now;
        if (got) tb_last = m;
    endtask

    // Both masters write in the same cycle; order and ack cycles come from the last-grant model.
    task automatic tie_pair();
        int exp_first;
        int first_m = -1, first_c = 0, second_m = -1, second_c = 0;
        int n = 0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        exp_first = (tb_last == 1) ? 0 : 1;
`else
        exp_first = 0;
`endif
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 8'h01, 64'h1234_5678_1234_5678);
        drive(1, 1'b1, 1'b1, 8'h02, 64'hdead_beef_0000_0001);
        for (int i = 1; i <= 12 && n < 2; i++) begin
            @(negedge clk);
            if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
                if (n == 0) begin first_m = m0_ack ? 0 : 1; first_c = i; end
                else        begin second_m = m0_ack ? 0 : 1; second_c = i; end
                drive(m0_ack ? 0 : 1, 1'b0, 1'b0, 8'h00, 64'd0);
                n++;
            end
        end
        drive(0, 1'b0, 1'b0, 8'h00, 64'd0);
        drive(1, 1'b0, 1'b0, 8'h00, 64'd0);
        chk("tie first master", 64'(first_m), 64'(exp_first));
        chk("tie first cycle", 64'(first_c), 64'd2);
        chk("tie second master", 64'(second_m), 64'(1 - exp_first));
        chk("tie second cycle", 64'(second_c), 64'd5);
        tb_last = 1 - exp_first;
    endtask

    initial begin
        int a0, a1, tot, m1_late;
        vecs[0] = '{0, 1'b1, 8'h00, 64'hffff_ffff_ffff_ffff, 64'h0};
        vecs[1] = '{0, 1'b0, 8'h00, 64'h0, 64'hffff_ffff_ffff_ffff};
        vecs[2] = '{0, 1'b1, 8'hff, 64'h0123_4567_89ab_cdef, 64'h0};
        vecs[3] = '{0, 1'b0, 8'hff, 64'h0, 64'h0123_4567_89ab_cdef};
        vecs[4] = '{0, 1'b0, 8'h00, 64'h0, 64'hffff_ffff_ffff_ffff};
        vecs[5] = '{1, 1'b1, 8'h03, 64'haaaa_5555_aaaa_5555, 64'h0};
        vecs[6] = '{1, 1'b0, 8'h03, 64'h0, 64'haaaa_5555_aaaa_5555};
        for (int i = 0; i < 256; i++) mem[i] = '0;

        repeat (2) @(negedge clk);
        chk_outputs_zero("por");
        reset_n = 1'b1;
        @(negedge clk);
        chk("post-reset busy", 64'(busy), 64'd0);

        for (int i = 0; i < 7; i++)
            txn(vecs[i].m, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);

        // Abort a write in ACCESS: everything must clear without a clock edge.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 8'h20, 64'h5555_6666_7777_8888);
        @(negedge clk);
        chk("pre-abort ram_cen", 64'(ram_cen), 64'd1);
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("abort access");
        drive(0, 1'b0, 1'b0, 8'h00, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tb_rdata = '0;
        tb_last = 1;
        repeat (3) @(negedge clk);
        chk("abort no ack", 64'({m0_ack, m1_ack}), 64'd0);

        tie_pair();
        txn(0, 1'b0, 8'h01, 64'd0, 64'h1234_5678_1234_5678);
        tie_pair();
        txn(1, 1'b0, 8'h02, 64'd0, 64'hdead_beef_0000_0001);
        txn(0, 1'b0, 8'h01, 64'd0, 64'h1234_5678_1234_5678);

        // Both requests held for ten grants, then m0 drops and m1 must get through.
        a0 = 0; a1 = 0; tot = 0; m1_late = 0;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 8'h10, 64'h1010_1010_1010_1010);
        drive(1, 1'b1, 1'b1, 8'h11, 64'h1111_1111_1111_1111);
        for (int i = 0; i < 60 && tot < 10; i++) begin
            @(negedge clk);
            if (m0_ack === 1'b1) begin a0++; tot++; end
            if (m1_ack === 1'b1) begin a1++; tot++; end
        end
        m0_req = 1'b0;
        for (int i = 0; i < 10 && m1_late == 0; i++) begin
            @(negedge clk);
            if (m1_ack === 1'b1) m1_late = 1;
        end
        m1_req = 1'b0;
        chk("held total acks", 64'(tot), 64'd10);
`ifdef RAM_ARB_ROUND_ROBIN_EN
        chk("held m0 acks", 64'(a0), 64'd5);
        chk("held m1 acks", 64'(a1), 64'd5);
`else
        chk("held m0 acks", 64'(a0), 64'd10);
        chk("held m1 acks", 64'(a1), 64'd0);
`endif
        chk("m1 granted after m0 drop", 64'(m1_late), 64'd1);
        tb_last = 1;

        // Reset during RDWAIT of an m1 read.
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 8'h01, 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rdwait busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("abort rdwait");
        @(negedge clk);
        reset_n = 1'b1;
        drive(1, 1'b0, 1'b0, 8'h00, 64'd0);
        tb_rdata = '0;
        tb_last = 1;
        a1 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (m1_ack === 1'b1) a1++;
        end
        chk("abort rdwait no ack", 64'(a1), 64'd0);
        chk("abort rdwait idle", 64'(busy), 64'd0);
        chk("abort rdwait rdata", rdata, 64'd0);
        txn(1, 1'b0, 8'h01, 64'd0, 64'h1234_5678_1234_5678);
        txn(0, 1'b0, 8'hff, 64'd0, 64'h0123_4567_89ab_cdef);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
